// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: live configuration, chip address rule and the
// chip-decode FSM state encoding.
package hyperbus_pkg;

  localparam int unsigned RuleAddrWidth = 32;
  localparam int unsigned RuleIdxWidth  = 32;

  // Chip address range; end_addr is exclusive.
  typedef struct packed {
    logic [RuleIdxWidth-1:0]  idx;
    logic [RuleAddrWidth-1:0] start_addr;
    logic [RuleAddrWidth-1:0] end_addr;
  } addr_rule_t;

  typedef struct packed {
    logic [4:0] t_latency_access;
    logic       en_latency_additional;
    logic [5:0] address_mask_msb;
    logic       address_space;
  } hyper_cfg_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StErr
  } dec_state_e;

  // Mask with bits [msb:0] set and everything above cleared.
  function automatic logic [63:0] low_mask(input logic [5:0] msb);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      m[i] = (6'(i) <= msb);
    end
    return m;
  endfunction

endpackage

// File: rtl/hyperbus_chip_match.sv
// Combinational range match of one address against all chip rules.
// Empty or inverted rules (start >= end) never hit; the lowest index wins.
module hyperbus_chip_match #(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter type         rule_t    = hyperbus_pkg::addr_rule_t,
  localparam int unsigned IdxWidth = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  rule_t                rules_i [NumChips],
  output logic                 hit_o,
  output logic [IdxWidth-1:0]  hit_idx_o
);

  // The idx field is carried for software bookkeeping only.
  logic [NumChips-1:0] unused_rule_idx;
  for (genvar g = 0; g < NumChips; g++) begin : gen_unused
    assign unused_rule_idx[g] = ^rules_i[g].idx;
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    logic [AddrWidth-1:0] lo;
    logic [AddrWidth-1:0] hi;
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = NumChips - 1; i >= 0; i--) begin
      lo = AddrWidth'(rules_i[i].start_addr);
      hi = AddrWidth'(rules_i[i].end_addr);
      if ((lo < hi) && (addr_i >= lo) && (addr_i < hi)) begin
        hit_o     = 1'b1;
        hit_idx_o = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/hyperbus_chip_decode.sv
// HyperBus chip-select decode: accepts an upstream request, maps it onto one
// chip range, and hands a chip-relative transfer downstream.
// Build option: HYPERBUS_DEC_ERR_EN -- when defined, unmapped addresses raise
// an error response; otherwise they fall through to chip 0 unmodified.
module hyperbus_chip_decode
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 16,
  parameter type         rule_t    = hyperbus_pkg::addr_rule_t,
  localparam int unsigned IdxWidth = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  hyper_cfg_t           cfg_i,
  input  rule_t                chip_rules_i [NumChips],
  // Upstream request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  // Downstream transfer
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  output logic                 trans_write_o,
  output logic [AddrWidth-1:0] trans_addr_o,
  output logic [LenWidth-1:0]  trans_len_o,
  output logic [NumChips-1:0]  trans_cs_o,
  input  logic                 trans_done_i,
  // Unmapped-address error response
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic                 trans_active_o
);

  dec_state_e           state_q, state_d;
  logic                 active_q, active_d;
  logic [NumChips-1:0]  cs_q, cs_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic                 write_q, write_d;

  logic                 match_hit;
  logic [IdxWidth-1:0]  match_idx;
  logic [AddrWidth-1:0] addr_mask;
  logic [AddrWidth-1:0] hit_start;

  // Only the mask width matters here; timing fields belong to the PHY side.
  logic unused_cfg;
  assign unused_cfg = ^cfg_i;

  hyperbus_chip_match #(
    .NumChips  (NumChips),
    .AddrWidth (AddrWidth),
    .rule_t    (rule_t)
  ) u_match (
    .addr_i    (req_addr_i),
    .rules_i   (chip_rules_i),
    .hit_o     (match_hit),
    .hit_idx_o (match_idx)
  );

  assign addr_mask = AddrWidth'(low_mask(cfg_i.address_mask_msb));
  assign hit_start = AddrWidth'(chip_rules_i[match_idx].start_addr);

  // Next-state and transfer register capture.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          len_d   = req_len_i;
          write_d = req_write_i;
          if (match_hit) begin
            state_d = StIssue;
            cs_d    = NumChips'(1) << match_idx;
            addr_d  = (req_addr_i - hit_start) & addr_mask;
          end else begin
`ifdef HYPERBUS_DEC_ERR_EN
            state_d = StErr;
            cs_d    = '0;
`else
            // Unmapped: fall through to chip 0 without offset subtraction.
            state_d = StIssue;
            cs_d    = NumChips'(1);
            addr_d  = req_addr_i & addr_mask;
`endif
          end
        end
      end
      StIssue: begin
        if (trans_ready_i) state_d = StBusy;
      end
      StBusy: begin
        if (trans_done_i) begin
          state_d = StIdle;
          cs_d    = '0;
        end
      end
      StErr: begin
        if (err_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    active_d = (state_d == StIssue) || (state_d == StBusy);
  end

  // State and transfer registers; reset drops any in-flight transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      cs_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      write_q  <= write_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign trans_valid_o  = (state_q == StIssue);
  assign trans_active_o = active_q;
  assign trans_cs_o     = cs_q & {NumChips{active_q}};
  assign trans_addr_o   = addr_q;
  assign trans_len_o    = len_q;
  assign trans_write_o  = write_q;

`ifdef HYPERBUS_DEC_ERR_EN
  assign err_valid_o = (state_q == StErr);
`else
  assign err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_chip_decode.sv
// Directed bench for hyperbus_chip_decode with hand-computed expectations.
module tb_hyperbus_chip_decode;
  import hyperbus_pkg::*;

  logic        clk;
  logic        rst_n;
  hyper_cfg_t  cfg;
  addr_rule_t  rules [2];
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        trans_valid, trans_ready, trans_write;
  logic [31:0] trans_addr;
  logic [15:0] trans_len;
  logic [1:0]  trans_cs;
  logic        trans_done;
  logic        err_valid, err_ready;
  logic        trans_active;

  int n_checks = 0;
  int n_fail   = 0;

  hyperbus_chip_decode #(
    .NumChips  (2),
    .AddrWidth (32),
    .LenWidth  (16),
    .rule_t    (addr_rule_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_i          (cfg),
    .chip_rules_i   (rules),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_len_i      (req_len),
    .trans_valid_o  (trans_valid),
    .trans_ready_i  (trans_ready),
    .trans_write_o  (trans_write),
    .trans_addr_o   (trans_addr),
    .trans_len_o    (trans_len),
    .trans_cs_o     (trans_cs),
    .trans_done_i   (trans_done),
    .err_valid_o    (err_valid),
    .err_ready_i    (err_ready),
    .trans_active_o (trans_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rule(input int i, input logic [31:0] s, input logic [31:0] e);
    rules[i].idx        = 32'(i);
    rules[i].start_addr = s;
    rules[i].end_addr   = e;
  endtask

  // Present a request for one edge; the DUT must be idle.
  task automatic send_req(input logic [31:0] a, input logic [15:0] l, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_write = w;
    step();
    req_valid = 1'b0;
  endtask

  // Handshake the issued transfer, then complete it.
  task automatic complete();
    trans_ready = 1'b1;
    step();
    trans_ready = 1'b0;
    trans_done  = 1'b1;
    step();
    trans_done  = 1'b0;
    check("complete_idle", 64'(req_ready), 64'd1);
  endtask

  initial begin
    cfg         = '0;
    cfg.address_mask_msb = 6'd25;
    set_rule(0, 32'h0000_0000, 32'h0100_0000);
    set_rule(1, 32'h0100_0000, 32'h0200_0000);
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    trans_ready = 1'b0;
    trans_done  = 1'b0;
    err_ready   = 1'b0;
    rst_n       = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(trans_valid), 64'd0);
    check("rst_cs", 64'(trans_cs), 64'd0);
    check("rst_active", 64'(trans_active), 64'd0);
    check("rst_err", 64'(err_valid), 64'd0);
    check("rst_addr", 64'(trans_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // Hit on chip 1, offset subtracted, one-cycle latency
    req_valid = 1'b1;
    req_addr  = 32'h0100_0040;
    req_len   = 16'd7;
    req_write = 1'b1;
    #1;
    check("pre_accept_valid", 64'(trans_valid), 64'd0);
    step();
    req_valid = 1'b0;
    check("hit1_valid", 64'(trans_valid), 64'd1);
    check("hit1_cs", 64'(trans_cs), 64'h2);
    check("hit1_addr", 64'(trans_addr), 64'h40);
    check("hit1_len", 64'(trans_len), 64'd7);
    check("hit1_write", 64'(trans_write), 64'd1);
    check("hit1_active", 64'(trans_active), 64'd1);
    check("hit1_req_ready", 64'(req_ready), 64'd0);

    // Stall in ISSUE for 5 cycles; a stray done pulse must be ignored
    for (int i = 0; i < 5; i++) begin
      trans_done = (i == 2);
      step();
      trans_done = 1'b0;
      check("stall_valid", 64'(trans_valid), 64'd1);
      check("stall_cs", 64'(trans_cs), 64'h2);
      check("stall_addr", 64'(trans_addr), 64'h40);
      check("stall_active", 64'(trans_active), 64'd1);
    end

    // Handshake into BUSY
    trans_ready = 1'b1;
    step();
    trans_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("busy_valid", 64'(trans_valid), 64'd0);
      check("busy_cs", 64'(trans_cs), 64'h2);
      check("busy_active", 64'(trans_active), 64'd1);
      step();
    end

    // done three cycles after ready, with a request already waiting
    trans_done = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0010;
    req_len    = 16'd3;
    req_write  = 1'b0;
    step();
    trans_done = 1'b0;
    check("done_req_ready", 64'(req_ready), 64'd1);
    check("done_no_accept", 64'(trans_valid), 64'd0);
    check("done_active", 64'(trans_active), 64'd0);
    check("done_cs", 64'(trans_cs), 64'd0);
    step();
    req_valid = 1'b0;
    check("next_valid", 64'(trans_valid), 64'd1);
    check("next_cs", 64'(trans_cs), 64'h1);
    check("next_addr", 64'(trans_addr), 64'h10);
    check("next_len", 64'(trans_len), 64'd3);
    check("next_write", 64'(trans_write), 64'd0);
    complete();

    // Narrow mask: 0x140 offset masked to bits [7:0]
    cfg.address_mask_msb = 6'd7;
    send_req(32'h0100_0140, 16'd0, 1'b0);
    check("mask_cs", 64'(trans_cs), 64'h2);
    check("mask_addr", 64'(trans_addr), 64'h40);
    complete();
    cfg.address_mask_msb = 6'd25;

    // Unmapped address
    send_req(32'h0300_0000, 16'd1, 1'b1);
`ifdef HYPERBUS_DEC_ERR_EN
    check("miss_err", 64'(err_valid), 64'd1);
    check("miss_cs", 64'(trans_cs), 64'd0);
    check("miss_valid", 64'(trans_valid), 64'd0);
    check("miss_active", 64'(trans_active), 64'd0);
    step();
    check("miss_err_hold", 64'(err_valid), 64'd1);
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    check("miss_err_clr", 64'(err_valid), 64'd0);
    check("miss_idle", 64'(req_ready), 64'd1);
`else
    check("miss_err", 64'(err_valid), 64'd0);
    check("miss_cs", 64'(trans_cs), 64'h1);
    check("miss_addr", 64'(trans_addr), 64'h0300_0000);
    check("miss_valid", 64'(trans_valid), 64'd1);
    complete();
`endif

    // Overlap: both rules cover 0x10, lowest index wins
    set_rule(0, 32'h0000_0000, 32'h0000_0100);
    set_rule(1, 32'h0000_0000, 32'h0000_0100);
    send_req(32'h0000_0010, 16'd0, 1'b0);
    check("overlap_cs", 64'(trans_cs), 64'h1);
    complete();

    // Empty rule 0 (start == end) never hits
    set_rule(0, 32'h0000_0010, 32'h0000_0010);
    send_req(32'h0000_0010, 16'd0, 1'b0);
    check("empty_cs", 64'(trans_cs), 64'h2);
    check("empty_addr", 64'(trans_addr), 64'h10);
    complete();

    // Inverted rule 0 (start > end) never hits
    set_rule(0, 32'h0000_0200, 32'h0000_0100);
    send_req(32'h0000_0010, 16'd0, 1'b0);
    check("inverted_cs", 64'(trans_cs), 64'h2);
    complete();

    // Reset while BUSY, then a stale done must be ignored
    set_rule(0, 32'h0000_0000, 32'h0100_0000);
    set_rule(1, 32'h0100_0000, 32'h0200_0000);
    send_req(32'h0000_0040, 16'd2, 1'b1);
    trans_ready = 1'b1;
    step();
    trans_ready = 1'b0;
    check("pre_rst_active", 64'(trans_active), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_active", 64'(trans_active), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_cs", 64'(trans_cs), 64'd0);
    check("midrst_valid", 64'(trans_valid), 64'd0);
    #2 rst_n = 1'b1;
    trans_done = 1'b1;
    step();
    trans_done = 1'b0;
    check("stale_req_ready", 64'(req_ready), 64'd1);
    check("stale_active", 64'(trans_active), 64'd0);
    check("stale_valid", 64'(trans_valid), 64'd0);
    send_req(32'h0100_0008, 16'd0, 1'b0);
    check("post_rst_cs", 64'(trans_cs), 64'h2);
    check("post_rst_addr", 64'(trans_addr), 64'h8);
    complete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
